// File: rtl/toggle_sched.sv
// Tick-enable scheduler for a bank of T-flop state bits.
// A prescaler issues one-cycle ticks that apply a mode-selected toggle pattern.
module toggle_sched #(
    parameter int N  = 4,
    parameter int PW = 25,
    parameter int BW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic [1:0]    mode,
    input  logic [PW-1:0] period,
    input  logic [BW-1:0] burst,
    output logic [N-1:0]  q,
    output logic [N-1:0]  qb,
    output logic [N-1:0]  t_vec,
    output logic          tick,
    output logic          busy,
    output logic          done
);

    localparam int PTRW = (N > 1) ? $clog2(N) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [1:0] M_ALL  = 2'd0;
    localparam logic [1:0] M_CNT  = 2'd1;
    localparam logic [1:0] M_WALK = 2'd2;
    localparam logic [1:0] M_ONES = 2'd3;

    logic [0:0]      state;
    logic [PW-1:0]   pc;
    logic [BW-1:0]   tc;
    logic [BW-1:0]   tc_nxt;
    logic [PTRW-1:0] ptr;
    logic [PTRW-1:0] ptr_nxt;
    logic [1:0]      mode_l;
    logic [PW-1:0]   period_l;
    logic [BW-1:0]   burst_l;
    logic [N-1:0]    t;
    logic [N-1:0]    one_hot;
    logic            at_tick;
    logic            last_tick;

    assign qb        = ~q;
    assign busy      = (state == RUN);
    assign tc_nxt    = tc + 1'b1;
    assign at_tick   = (pc == period_l);
    assign last_tick = (burst_l != '0) && (tc_nxt == burst_l);
    assign ptr_nxt   = (ptr == PTRW'(N - 1)) ? '0 : ptr + 1'b1;
    assign one_hot   = {{(N-1){1'b0}}, 1'b1} << ptr;

    // Toggle pattern for the next tick, always derived from the current q.
    always_comb begin
        t = '0;
        case (mode_l)
            M_ALL: t = '1;
            M_CNT: begin
                t[0] = 1'b1;
                for (int i = 1; i < N; i++) begin
                    t[i] = t[i-1] & q[i-1];
                end
            end
            M_WALK: t = one_hot;
            M_ONES: t = ~q;
            default: t = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            q        <= '0;
            t_vec    <= '0;
            tick     <= 1'b0;
            done     <= 1'b0;
            pc       <= '0;
            tc       <= '0;
            ptr      <= '0;
            mode_l   <= '0;
            period_l <= '0;
            burst_l  <= '0;
        end else begin
            tick  <= 1'b0;
            t_vec <= '0;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !stop) begin
                        state    <= RUN;
                        mode_l   <= mode;
                        period_l <= period;
                        burst_l  <= burst;
                        pc       <= '0;
                        tc       <= '0;
                        ptr      <= '0;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state <= IDLE;
                    end else if (at_tick) begin
                        pc    <= '0;
                        tick  <= 1'b1;
                        t_vec <= t;
                        // XOR with ~q yields all ones, covering preset mode.
                        q     <= q ^ t;
                        tc    <= tc_nxt;
                        if (mode_l == M_WALK) begin
                            ptr <= ptr_nxt;
                        end
                        if (last_tick) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end else begin
                        pc <= pc + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_toggle_sched.sv
// Directed bench for toggle_sched with hand-computed expectations.
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
module tb_toggle_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic [1:0]  mode;
    logic [24:0] period;
    logic [7:0]  burst;
    logic [3:0]  q;
    logic [3:0]  qb;
    logic [3:0]  t_vec;
    logic        tick;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;
    int done_seen;

    toggle_sched dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .stop   (stop),
        .mode   (mode),
        .period (period),
        .burst  (burst),
        .q      (q),
        .qb     (qb),
        .t_vec  (t_vec),
        .tick   (tick),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [1:0] m, input int p, input int b);
        mode   = m;
        period = 25'(p);
        burst  = 8'(b);
        start  = 1'b1;
        step();
        start  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    logic [3:0] m2_t [5] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
    logic [3:0] m2_q [5] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE};

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0;
        mode = '0; period = '0; burst = '0;
        step();
        step();
        check("rst_q", q, 4'h0);
        check("rst_qb", qb, 4'hF);
        check("rst_busy", busy, 1'b0);
        check("rst_tick", tick, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_tvec", t_vec, 4'h0);
        rst = 1'b0;

        // mode 0: period 2, burst 3 -> ticks at E+3, E+6, E+9
        go(2'd0, 2, 3);
        check("m0_busy", busy, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step();
            check("m0_gap_tick", tick, 1'b0);
            step();
            check("m0_gap_tick", tick, 1'b0);
            step();
            check("m0_tick", tick, 1'b1);
            check("m0_q", q, (k % 2 == 0) ? 4'hF : 4'h0);
            check("m0_tvec", t_vec, 4'hF);
        end
        check("m0_done", done, 1'b1);
        check("m0_busy_end", busy, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step();
            check("m0_after_tick", tick, 1'b0);
            check("m0_after_done", done, 1'b0);
        end

        // mode 1: continuous binary count every cycle
        do_reset();
        go(2'd1, 0, 0);
        done_seen = 0;
        for (int k = 1; k <= 16; k++) begin
            step();
            if (done) done_seen++;
            check("m1_q", q, 32'(k % 16));
            check("m1_busy", busy, 1'b1);
        end
        check("m1_wrap_tvec", t_vec, 4'hF);
        check("m1_no_done", done_seen, 0);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("m1_stop_busy", busy, 1'b0);
        check("m1_stop_q", q, 4'h0);
        check("m1_stop_tick", tick, 1'b0);

        // mode 2: walking one, period 1, burst 5
        go(2'd2, 1, 5);
        for (int k = 0; k < 5; k++) begin
            step();
            check("m2_gap_tick", tick, 1'b0);
            step();
            check("m2_tvec", t_vec, m2_t[k]);
            check("m2_q", q, m2_q[k]);
        end
        check("m2_done", done, 1'b1);
        check("m2_busy", busy, 1'b0);

        // count to 0101 with a 5-tick burst, then preset-ones right after
        do_reset();
        go(2'd1, 0, 5);
        for (int k = 0; k < 5; k++) step();
        check("m1b_q", q, 4'h5);
        check("m1b_done", done, 1'b1);
        go(2'd3, 0, 2);
        check("m3_restart_busy", busy, 1'b1);
        step();
        check("m3_q1", q, 4'hF);
        check("m3_tvec1", t_vec, 4'hA);
        check("m3_done1", done, 1'b0);
        step();
        check("m3_tick2", tick, 1'b1);
        check("m3_tvec2", t_vec, 4'h0);
        check("m3_q2", q, 4'hF);
        check("m3_done2", done, 1'b1);
        check("m3_qb", qb, 4'h0);

        // stop on the edge where pc == period
        do_reset();
        go(2'd0, 3, 0);
        step();
        step();
        step();
        check("stop_pre_tick", tick, 1'b0);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("stop_tick", tick, 1'b0);
        check("stop_q", q, 4'h0);
        check("stop_busy", busy, 1'b0);
        check("stop_done", done, 1'b0);

        // start and stop together in IDLE
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        check("ss_busy", busy, 1'b0);

        // start while busy must not relatch config
        go(2'd0, 1, 0);
        mode   = 2'd1;
        period = 25'd0;
        start  = 1'b1;
        step();
        check("rb_tick1", tick, 1'b0);
        step();
        start = 1'b0;
        check("rb_tick2", tick, 1'b1);
        check("rb_q", q, 4'hF);
        step();
        check("rb_tick3", tick, 1'b0);

        // reset mid-run
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rr_q", q, 4'h0);
        check("rr_qb", qb, 4'hF);
        check("rr_busy", busy, 1'b0);
        check("rr_tick", tick, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
